// File: rtl/hci_cmd_dispatch.sv
// HCI command dispatcher: pops command descriptors, hands them to the execution FSM,
// streams TX write data and pushes a response descriptor. Optional watchdog: HCI_CMD_DISPATCH_TIMEOUT_EN.
module hci_cmd_dispatch #(
    parameter int CmdDataWidth  = 64,
    parameter int TxDataWidth   = 32,
    parameter int RespDataWidth = 32,
    parameter int TimeoutCycles = 65535
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     cmd_rvalid_i,
    output logic                     cmd_rready_o,
    input  logic [CmdDataWidth-1:0]  cmd_rdata_i,
    input  logic                     tx_rvalid_i,
    output logic                     tx_rready_o,
    input  logic [TxDataWidth-1:0]   tx_rdata_i,
    output logic                     resp_wvalid_o,
    input  logic                     resp_wready_i,
    output logic [RespDataWidth-1:0] resp_wdata_o,
    output logic                     exec_valid_o,
    input  logic                     exec_ready_i,
    output logic [CmdDataWidth-1:0]  exec_cmd_o,
    output logic                     xfer_tx_valid_o,
    input  logic                     xfer_tx_ready_i,
    output logic [TxDataWidth-1:0]   xfer_tx_data_o,
    input  logic                     xfer_done_i,
    input  logic [3:0]               xfer_err_i,
    input  logic [15:0]              xfer_len_i,
    output logic                     busy_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        OFFER  = 3'd2,
        TX     = 3'd3,
        EXEC   = 3'd4,
        RESP   = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic [CmdDataWidth-1:0] cmd_q, cmd_d;
    logic [15:0]             words_q, words_d;
    logic [3:0]              err_q, err_d;
    logic [15:0]             len_q, len_d;
    logic [16:0]             len_plus3;
    logic                    tx_fire;
    logic                    tmo_hit;

    // 17-bit sum so DATA_LENGTH=0xFFFF rounds up to 16384 words without wrapping
    assign len_plus3 = {1'b0, cmd_q[63:48]} + 17'd3;
    assign tx_fire   = xfer_tx_ready_i & tx_rvalid_i;

`ifdef HCI_CMD_DISPATCH_TIMEOUT_EN
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_active;

    assign tmo_active = (state_q == OFFER) || (state_q == TX) || (state_q == EXEC);
    assign tmo_hit    = tmo_active && (tmo_cnt_q == 16'(TimeoutCycles - 1));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == DECODE) begin
            tmo_cnt_d = '0;
        end else if (tmo_active) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        words_d         = words_q;
        err_d           = err_q;
        len_d           = len_q;
        cmd_rready_o    = 1'b0;
        tx_rready_o     = 1'b0;
        resp_wvalid_o   = 1'b0;
        resp_wdata_o    = '0;
        exec_valid_o    = 1'b0;
        xfer_tx_valid_o = 1'b0;
        xfer_tx_data_o  = '0;

        case (state_q)
            IDLE: begin
                cmd_rready_o = cmd_rvalid_i;
                if (cmd_rvalid_i) begin
                    cmd_d   = cmd_rdata_i;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (cmd_q[2:0] > 3'd1) begin
                    err_d   = 4'h9;
                    len_d   = '0;
                    state_d = RESP;
                end else begin
                    words_d = {1'b0, len_plus3[16:2]};
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (tmo_hit) begin
                    err_d   = 4'hF;
                    len_d   = '0;
                    state_d = RESP;
                end else begin
                    exec_valid_o = 1'b1;
                    if (exec_ready_i) begin
                        if (cmd_q[2:0] == 3'd0 && !cmd_q[29] && words_q != 16'd0) begin
                            state_d = TX;
                        end else begin
                            state_d = EXEC;
                        end
                    end
                end
            end
            TX: begin
                if (tmo_hit) begin
                    err_d   = 4'hF;
                    len_d   = '0;
                    words_d = '0;
                    state_d = RESP;
                end else begin
                    xfer_tx_valid_o = tx_rvalid_i;
                    xfer_tx_data_o  = tx_rdata_i;
                    tx_rready_o     = tx_fire;
                    // Early abort from the execution FSM wins over the word counter
                    if (xfer_done_i) begin
                        err_d   = xfer_err_i;
                        len_d   = xfer_len_i;
                        words_d = '0;
                        state_d = RESP;
                    end else if (tx_fire) begin
                        words_d = words_q - 16'd1;
                        if (words_q == 16'd1) begin
                            state_d = EXEC;
                        end
                    end
                end
            end
            EXEC: begin
                if (tmo_hit) begin
                    err_d   = 4'hF;
                    len_d   = '0;
                    state_d = RESP;
                end else if (xfer_done_i) begin
                    err_d   = xfer_err_i;
                    len_d   = xfer_len_i;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_wvalid_o = 1'b1;
                resp_wdata_o  = {err_q, cmd_q[6:3], 8'h00, len_q};
                if (resp_wready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            words_q <= '0;
            err_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            words_q <= words_d;
            err_q   <= err_d;
            len_q   <= len_d;
        end
    end

    assign exec_cmd_o = cmd_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_hci_cmd_dispatch.sv
// Directed bench for hci_cmd_dispatch with response and TX-word scoreboards.
module tb_hci_cmd_dispatch;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         cmd_rvalid_i = 1'b0;
    logic         cmd_rready_o;
    logic [63:0]  cmd_rdata_i = '0;
    logic         tx_rvalid_i = 1'b0;
    logic         tx_rready_o;
    logic [31:0]  tx_rdata_i = '0;
    logic         resp_wvalid_o;
    logic         resp_wready_i = 1'b1;
    logic [31:0]  resp_wdata_o;
    logic         exec_valid_o;
    logic         exec_ready_i = 1'b1;
    logic [63:0]  exec_cmd_o;
    logic         xfer_tx_valid_o;
    logic         xfer_tx_ready_i = 1'b1;
    logic [31:0]  xfer_tx_data_o;
    logic         xfer_done_i = 1'b0;
    logic [3:0]   xfer_err_i = '0;
    logic [15:0]  xfer_len_i = '0;
    logic         busy_o;

    always #5 clk_i = ~clk_i;

    hci_cmd_dispatch #(.TimeoutCycles(100)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .cmd_rvalid_i(cmd_rvalid_i), .cmd_rready_o(cmd_rready_o), .cmd_rdata_i(cmd_rdata_i),
        .tx_rvalid_i(tx_rvalid_i), .tx_rready_o(tx_rready_o), .tx_rdata_i(tx_rdata_i),
        .resp_wvalid_o(resp_wvalid_o), .resp_wready_i(resp_wready_i), .resp_wdata_o(resp_wdata_o),
        .exec_valid_o(exec_valid_o), .exec_ready_i(exec_ready_i), .exec_cmd_o(exec_cmd_o),
        .xfer_tx_valid_o(xfer_tx_valid_o), .xfer_tx_ready_i(xfer_tx_ready_i),
        .xfer_tx_data_o(xfer_tx_data_o), .xfer_done_i(xfer_done_i), .xfer_err_i(xfer_err_i),
        .xfer_len_i(xfer_len_i), .busy_o(busy_o)
    );

    int total = 0;
    int bad = 0;
    int n_cmdpop = 0, n_txpop = 0, n_exec = 0, n_execv = 0, n_resp = 0;
    int tx_skip = 0;
    bit tx_en = 1'b0;
    logic [31:0] exp_resp[$];
    logic [31:0] exp_tx[$];
    logic [31:0] tx_src[$];

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshakes are sampled mid-cycle; they complete at the following rising edge.
    always @(negedge clk_i) begin
        logic [31:0] e;
        if (rst_ni) begin
            if (cmd_rvalid_i && cmd_rready_o) n_cmdpop++;
            if (tx_rvalid_i && tx_rready_o) n_txpop++;
            if (exec_valid_o) n_execv++;
            if (exec_valid_o && exec_ready_i) n_exec++;
            if (xfer_tx_valid_o && xfer_tx_ready_i) begin
                if (exp_tx.size() == 0) chk("tx_extra_word", 136'(exp_tx.size()), 136'd1);
                else begin
                    e = exp_tx.pop_front();
                    chk("tx_word", 136'(xfer_tx_data_o), 136'(e));
                end
            end
            if (resp_wvalid_o && resp_wready_i) begin
                n_resp++;
                if (exp_resp.size() == 0) chk("resp_extra", 136'(exp_resp.size()), 136'd1);
                else begin
                    e = exp_resp.pop_front();
                    chk("resp_data", 136'(resp_wdata_o), 136'(e));
                end
            end
        end
    end

    // TX queue model: presents the word after the ones already popped.
    always @(posedge clk_i) begin
        #2;
        if (tx_en && (n_txpop + tx_skip) < tx_src.size()) begin
            tx_rvalid_i = 1'b1;
            tx_rdata_i  = tx_src[n_txpop + tx_skip];
        end else begin
            tx_rvalid_i = 1'b0;
            tx_rdata_i  = '0;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic int cnt_of(input int which);
        case (which)
            0: return n_cmdpop;
            1: return n_txpop;
            2: return n_exec;
            default: return n_resp;
        endcase
    endfunction

    task automatic wait_cnt(input string tag, input int which, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (cnt_of(which) >= target) break;
            tick();
        end
        chk(tag, 136'(cnt_of(which)), 136'(target));
    endtask

    task automatic send_cmd(input logic [63:0] c);
        int t;
        t = n_cmdpop + 1;
        cmd_rdata_i  = c;
        cmd_rvalid_i = 1'b1;
        wait_cnt("cmd_pop", 0, t, 50);
        cmd_rvalid_i = 1'b0;
        cmd_rdata_i  = '0;
    endtask

    task automatic pulse_done(input logic [3:0] err, input logic [15:0] len);
        xfer_err_i  = err;
        xfer_len_i  = len;
        xfer_done_i = 1'b1;
        tick();
        xfer_done_i = 1'b0;
        xfer_err_i  = '0;
        xfer_len_i  = '0;
    endtask

    task automatic flush_tx();
        tx_en   = 1'b0;
        tx_skip = tx_src.size() - n_txpop;
    endtask

    function automatic logic [135:0] all_outs();
        return 136'({cmd_rready_o, tx_rready_o, resp_wvalid_o, exec_valid_o, xfer_tx_valid_o,
                     busy_o, resp_wdata_o, xfer_tx_data_o, exec_cmd_o});
    endfunction

    initial begin
        int b;
        int cyc;
        logic [63:0] c;

        tick();
        tick();
        chk("reset_outputs", all_outs(), 136'd0);
        rst_ni = 1'b1;
        tick();

        // Immediate command; a decoy TX word must stay untouched
        tx_src.push_back(32'hDEAD_BEEF);
        tx_en = 1'b1;
        exp_resp.push_back(32'h0500_0004);
        b = n_txpop;
        send_cmd(64'h0000_0000_0000_0029);
        chk("t1_exec_cmd", 136'(exec_cmd_o), 136'(64'h29));
        chk("t1_busy", 136'(busy_o), 136'd1);
        wait_cnt("t1_exec_hs", 2, n_exec + 1, 10);
        pulse_done(4'h0, 16'd4);
        wait_cnt("t1_resp", 3, n_resp + 1, 10);
        chk("t1_no_tx_pop", 136'(n_txpop - b), 136'd0);
        flush_tx();

        // Regular write, 7 bytes -> 2 words; third queued word must stay
        tx_src.push_back(32'h1111_0001); exp_tx.push_back(32'h1111_0001);
        tx_src.push_back(32'h2222_0002); exp_tx.push_back(32'h2222_0002);
        tx_src.push_back(32'h3333_0003);
        tx_en = 1'b1;
        exp_resp.push_back(32'h0200_0007);
        c = '0; c[63:48] = 16'd7; c[6:3] = 4'd2;
        b = n_txpop;
        send_cmd(c);
        wait_cnt("t2_tx_pops", 1, b + 2, 30);
        tick();
        chk("t2_no_third_pop", 136'(tx_rready_o), 136'd0);
        chk("t2_busy_exec", 136'(busy_o), 136'd1);
        pulse_done(4'h0, 16'd7);
        wait_cnt("t2_resp", 3, n_resp + 1, 10);
        chk("t2_total_pops", 136'(n_txpop - b), 136'd2);
        flush_tx();

        // Unsupported ATTR: never offered to execution
        exp_resp.push_back(32'h9100_0000);
        b = n_execv;
        send_cmd(64'h0000_0000_0000_000B);
        wait_cnt("t3_resp", 3, n_resp + 1, 10);
        chk("t3_no_exec_valid", 136'(n_execv - b), 136'd0);

        // Response backpressure with a second command pending
        resp_wready_i = 1'b0;
        exp_resp.push_back(32'h2300_0010);
        send_cmd(64'h0000_0000_0000_0019);
        wait_cnt("t4_exec_hs", 2, n_exec + 1, 10);
        pulse_done(4'h2, 16'h0010);
        exp_resp.push_back(32'h0500_0004);
        cmd_rdata_i  = 64'h0000_0000_0000_0029;
        cmd_rvalid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("t4_resp_valid", 136'(resp_wvalid_o), 136'd1);
            chk("t4_resp_stable", 136'(resp_wdata_o), 136'(32'h2300_0010));
            chk("t4_no_pop", 136'(cmd_rready_o), 136'd0);
            tick();
        end
        resp_wready_i = 1'b1;
        chk("t4_no_pop_hs", 136'(cmd_rready_o), 136'd0);
        tick();
        chk("t4_pop_next", 136'(cmd_rready_o), 136'd1);
        wait_cnt("t4_pop2", 0, n_cmdpop + 1, 5);
        cmd_rvalid_i = 1'b0;
        wait_cnt("t4_exec_hs2", 2, n_exec + 1, 10);
        pulse_done(4'h0, 16'd4);
        wait_cnt("t4_resp2", 3, n_resp + 1, 10);

        // TX queue runs dry mid-transfer for 20 cycles
        tx_src.push_back(32'hA000_0000); exp_tx.push_back(32'hA000_0000);
        tx_src.push_back(32'hA000_0001); exp_tx.push_back(32'hA000_0001);
        tx_en = 1'b1;
        exp_resp.push_back(32'h0400_0010);
        c = '0; c[63:48] = 16'd16; c[6:3] = 4'd4;
        b = n_txpop;
        send_cmd(c);
        wait_cnt("t5_first_half", 1, b + 2, 30);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("t5_stall_valid", 136'(xfer_tx_valid_o), 136'd0);
            chk("t5_stall_busy", 136'(busy_o), 136'd1);
        end
        tx_src.push_back(32'hA000_0002); exp_tx.push_back(32'hA000_0002);
        tx_src.push_back(32'hA000_0003); exp_tx.push_back(32'hA000_0003);
        wait_cnt("t5_second_half", 1, b + 4, 10);
        pulse_done(4'h0, 16'd16);
        wait_cnt("t5_resp", 3, n_resp + 1, 10);
        flush_tx();

        // Early abort during TX after one word
        for (int i = 0; i < 4; i++) tx_src.push_back(32'hB000_0000 + 32'(i));
        exp_tx.push_back(32'hB000_0000);
        tx_en = 1'b1;
        exp_resp.push_back(32'h3600_0004);
        c = '0; c[63:48] = 16'd16; c[6:3] = 4'd6;
        b = n_txpop;
        send_cmd(c);
        wait_cnt("t6_one_word", 1, b + 1, 30);
        xfer_tx_ready_i = 1'b0;
        tick();
        pulse_done(4'h3, 16'd4);
        xfer_tx_ready_i = 1'b1;
        wait_cnt("t6_resp", 3, n_resp + 1, 10);
        tick();
        tick();
        chk("t6_no_more_pops", 136'(n_txpop - b), 136'd1);
        flush_tx();

        // Read and zero-length write never touch the TX queue
        tx_src.push_back(32'hC0DE_0000);
        tx_en = 1'b1;
        b = n_txpop;
        exp_resp.push_back(32'h0700_0008);
        c = '0; c[63:48] = 16'd8; c[29] = 1'b1; c[6:3] = 4'd7;
        send_cmd(c);
        wait_cnt("t7_exec_hs", 2, n_exec + 1, 10);
        pulse_done(4'h0, 16'd8);
        wait_cnt("t7_resp", 3, n_resp + 1, 10);
        exp_resp.push_back(32'h0100_0000);
        send_cmd(64'h0000_0000_0000_0008);
        wait_cnt("t7_exec_hs0", 2, n_exec + 1, 10);
        pulse_done(4'h0, 16'd0);
        wait_cnt("t7_resp0", 3, n_resp + 1, 10);
        chk("t7_no_tx_pop", 136'(n_txpop - b), 136'd0);
        flush_tx();

        // Stray done pulse in IDLE is ignored
        b = n_resp;
        pulse_done(4'h5, 16'd3);
        tick();
        tick();
        chk("t8_idle_busy", 136'(busy_o), 136'd0);
        chk("t8_no_resp", 136'(n_resp - b), 136'd0);

`ifdef HCI_CMD_DISPATCH_TIMEOUT_EN
        exec_ready_i = 1'b0;
        exp_resp.push_back(32'hF500_0000);
        send_cmd(64'h0000_0000_0000_0029);
        cyc = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            cyc++;
            if (resp_wvalid_o) break;
        end
        chk("t9_timeout_cycles", 136'(cyc), 136'd101);
        chk("t9_exec_dropped", 136'(exec_valid_o), 136'd0);
        exec_ready_i = 1'b1;
        wait_cnt("t9_resp", 3, n_resp + 1, 10);
`else
        cyc = 0;
`endif

        // Asynchronous reset in the middle of TX
        tx_src.push_back(32'hD000_0000); exp_tx.push_back(32'hD000_0000);
        tx_src.push_back(32'hD000_0001);
        tx_en = 1'b1;
        c = '0; c[63:48] = 16'd8; c[6:3] = 4'd1;
        b = n_txpop;
        send_cmd(c);
        wait_cnt("t10_one_word", 1, b + 1, 30);
        rst_ni = 1'b0;
        #1;
        chk("t10_async_reset", all_outs(), 136'd0);
        flush_tx();
        tick();
        rst_ni = 1'b1;
        tick();
        chk("t10_idle_after", 136'(busy_o), 136'd0);

        chk("end_resp_queue", 136'(exp_resp.size()), 136'd0);
        chk("end_tx_queue", 136'(exp_tx.size()), 136'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
